mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 33 +++
 rtl/mdu_core.sv | 63 ++++++
 rtl/mdu_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_ctrl_pkg
//  Brief    : Shared MDU op codes, default cycle counts and op-class helpers.
//  Revision : 1.0  initial release
// ============================================================================
package mdu_ctrl_pkg;

   // MDUOp encodings; every other code behaves as NONE
   localparam logic [3:0] c_op_none  = 4'd0;
   localparam logic [3:0] c_op_mult  = 4'd1;
   localparam logic [3:0] c_op_multu = 4'd2;
   localparam logic [3:0] c_op_div   = 4'd3;
   localparam logic [3:0] c_op_divu  = 4'd4;
   localparam logic [3:0] c_op_mthi  = 4'd5;
   localparam logic [3:0] c_op_mtlo  = 4'd6;

   // Default busy lengths of the multi-cycle ops
   localparam int c_mult_cycles = 5;
   localparam int c_div_cycles  = 10;

   // Multiply class: MULT or MULTU
   function automatic logic op_is_mult(input logic [3:0] op);
      return (op == c_op_mult) || (op == c_op_multu);
   endfunction

   // Divide class: DIV or DIVU
   function automatic logic op_is_div(input logic [3:0] op);
      return (op == c_op_div) || (op == c_op_divu);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_core.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_core
//  Brief    : Combinational multiply/divide datapath. Produces {HI,LO} for the
//             latched op and flags a zero divisor.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_core
   import mdu_ctrl_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        div_zero
);

   logic        w_signed_div;
   logic [31:0] w_dividend;
   logic [31:0] w_divisor_mag;
   logic [31:0] w_divisor;
   logic [31:0] w_quo_mag;
   logic [31:0] w_rem_mag;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic [63:0] w_sprod;
   logic [63:0] w_uprod;

   // Signed divide runs on magnitudes so 0x80000000 / -1 cannot overflow
   assign w_signed_div  = (op == c_op_div);
   assign w_dividend    = (w_signed_div && a[31]) ? (~a + 32'd1) : a;
   assign w_divisor_mag = (w_signed_div && b[31]) ? (~b + 32'd1) : b;
   // A zero divisor is replaced by 1 only to keep the divider defined;
   // the result is discarded via div_zero
   assign w_divisor     = (b == 32'd0) ? 32'd1 : w_divisor_mag;
   assign w_quo_mag     = w_dividend / w_divisor;
   assign w_rem_mag     = w_dividend % w_divisor;

   // Quotient sign is the XOR of operand signs; remainder follows the dividend
   assign w_quo = (w_signed_div && (a[31] ^ b[31])) ? (~w_quo_mag + 32'd1) : w_quo_mag;
   assign w_rem = (w_signed_div && a[31])           ? (~w_rem_mag + 32'd1) : w_rem_mag;

   assign w_sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign w_uprod = {32'd0, a} * {32'd0, b};

   // Select the 64-bit result for the latched op
   always_comb begin
      result   = 64'd0;
      div_zero = 1'b0;
      case (op)
         c_op_mult:  result = w_sprod;
         c_op_multu: result = w_uprod;
         c_op_div,
         c_op_divu: begin
            result   = {w_rem, w_quo};
            div_zero = (b == 32'd0);
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_ctrl
//  Brief    : Multiply/divide unit control: op acceptance, busy counter,
//             operand latches and the HI/LO registers.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = c_mult_cycles,
   parameter int DIV_CYCLES  = c_div_cycles
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] RData1,
   input  logic [31:0] RData2,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

   logic [3:0]         r_op;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_busy;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic [63:0]        w_result;
   logic               w_div_zero;

   mdu_core u_core (
      .op       (r_op),
      .a        (r_a),
      .b        (r_b),
      .result   (w_result),
      .div_zero (w_div_zero)
   );

   // Accept ops when idle, count down in-flight ops and commit HI/LO
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op   <= c_op_none;
         r_a    <= 32'd0;
         r_b    <= 32'd0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
      end else if (r_cnt != '0) begin
         // Start is ignored while busy; the last count commits the result
         r_cnt  <= r_cnt - c_cnt_w'(1);
         r_busy <= (r_cnt != c_cnt_w'(1));
         if ((r_cnt == c_cnt_w'(1)) && !w_div_zero) begin
            r_hi <= w_result[63:32];
            r_lo <= w_result[31:0];
         end
      end else if (Start) begin
         if (op_is_mult(MDUOp) || op_is_div(MDUOp)) begin
            r_op   <= MDUOp;
            r_a    <= RData1;
            r_b    <= RData2;
            r_cnt  <= op_is_mult(MDUOp) ? c_cnt_w'(MULT_CYCLES) : c_cnt_w'(DIV_CYCLES);
            r_busy <= 1'b1;
         end else if (MDUOp == c_op_mthi) begin
            r_hi <= RData1;
         end else if (MDUOp == c_op_mtlo) begin
            r_lo <= RData1;
         end
      end
   end

   assign Busy = r_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule
`default_nettype wire
